// File: rtl/modulo_counter_chain.sv
// modulo_counter_chain
//   A cascade of NUM_STAGES modulo-STAGE_MOD digit counters. Stage 0 is the
//   least significant digit. The ripple enable is purely combinational, so the
//   whole chain steps as a single counter with no carry latency. It counts up
//   or down, and it supports synchronous clear and parallel load (clear wins
//   over load, and load wins over enable). A digit loaded with a value of
//   STAGE_MOD or more saturates to STAGE_MOD-1.
//
//   Optional feature macro: COUNTER_CHAIN_SNAPSHOT_EN
//     When defined, snap_strobe captures the post-update count into snap_count
//     at that edge, which gives a coherent multi-digit read.
//     When undefined, snap_count is tied to zero and no snapshot register exists.
module modulo_counter_chain #(
    parameter int STAGE_WIDTH = 4,
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_MOD   = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              enable,
    input  logic                              up_down,
    input  logic                              load,
    input  logic [NUM_STAGES*STAGE_WIDTH-1:0] load_value,
    output logic [NUM_STAGES*STAGE_WIDTH-1:0] count,
    output logic                              terminal_count,
    output logic                              wrap_pulse,
    input  logic                              snap_strobe,
    output logic [NUM_STAGES*STAGE_WIDTH-1:0] snap_count
);

    localparam int CW = NUM_STAGES * STAGE_WIDTH;
    localparam logic [STAGE_WIDTH-1:0] MAX_DIGIT = STAGE_WIDTH'(STAGE_MOD - 1);

    generate
        if (STAGE_MOD < 2 || STAGE_MOD > (2 ** STAGE_WIDTH)) begin : g_bad_mod
            $error("modulo_counter_chain: STAGE_MOD must lie in [2, 2**STAGE_WIDTH]");
        end
    endgenerate

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic [NUM_STAGES-1:0] digit_term;
    logic [NUM_STAGES-1:0] stage_en;

    assign count = count_q;

    // Per-digit terminal detection and ripple enable; the chain is terminal when every digit is.
    always_comb begin
        logic carry;
        digit_term = '0;
        stage_en   = '0;
        carry      = enable;
        for (int j = 0; j < NUM_STAGES; j++) begin
            digit_term[j] = up_down ? (count_q[j*STAGE_WIDTH +: STAGE_WIDTH] == MAX_DIGIT)
                                    : (count_q[j*STAGE_WIDTH +: STAGE_WIDTH] == '0);
            stage_en[j]   = carry;
            carry         = carry & digit_term[j];
        end
        terminal_count = carry;
    end

    // Next digit values: clear beats load, and load beats counting.
    always_comb begin
        count_next = count_q;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                count_next[j*STAGE_WIDTH +: STAGE_WIDTH] =
                    (load_value[j*STAGE_WIDTH +: STAGE_WIDTH] > MAX_DIGIT)
                        ? MAX_DIGIT : load_value[j*STAGE_WIDTH +: STAGE_WIDTH];
            end
        end else begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                if (stage_en[j]) begin
                    if (up_down) begin
                        count_next[j*STAGE_WIDTH +: STAGE_WIDTH] = digit_term[j] ? '0
                            : count_q[j*STAGE_WIDTH +: STAGE_WIDTH] + STAGE_WIDTH'(1);
                    end else begin
                        count_next[j*STAGE_WIDTH +: STAGE_WIDTH] = digit_term[j] ? MAX_DIGIT
                            : count_q[j*STAGE_WIDTH +: STAGE_WIDTH] - STAGE_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    // One-cycle wrap flag. A clear or load on the wrapping edge suppresses it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= terminal_count & ~clear & ~load;
        end
    end

`ifdef COUNTER_CHAIN_SNAPSHOT_EN
    logic [CW-1:0] snap_q;

    // Capture the value the counter takes at this edge, including a clear or a load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_q <= '0;
        end else if (snap_strobe) begin
            snap_q <= count_next;
        end
    end

    assign snap_count = snap_q;
`else
    logic snap_unused;
    assign snap_unused = snap_strobe;
    assign snap_count  = '0;
`endif

endmodule

// File: tb/tb_modulo_counter_chain.sv
// Bench for modulo_counter_chain.
// It runs a default 4x4 BCD instance through a table of vectors and some
// hand-written reset and snapshot sequences. A second 3x8-bit modulo-256
// instance is checked against a 24-bit binary model.
module tb_modulo_counter_chain;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance (4 x 4-bit, mod 10) ----------------
    logic        clear, enable, up_down, load, snap_strobe;
    logic [15:0] load_value;
    logic [15:0] count, snap_count;
    logic        terminal_count, wrap_pulse;

    modulo_counter_chain dut (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable),
        .up_down(up_down), .load(load), .load_value(load_value),
        .count(count), .terminal_count(terminal_count), .wrap_pulse(wrap_pulse),
        .snap_strobe(snap_strobe), .snap_count(snap_count)
    );

    // ---------------- binary instance (3 x 8-bit, mod 256) ----------------
    logic        clear2, enable2, up_down2, load2, snap_strobe2;
    logic [23:0] load_value2;
    logic [23:0] count2, snap_count2;
    logic        terminal_count2, wrap_pulse2;

    modulo_counter_chain #(.STAGE_WIDTH(8), .NUM_STAGES(3), .STAGE_MOD(256)) dut2 (
        .clk(clk), .reset(reset), .clear(clear2), .enable(enable2),
        .up_down(up_down2), .load(load2), .load_value(load_value2),
        .count(count2), .terminal_count(terminal_count2), .wrap_pulse(wrap_pulse2),
        .snap_strobe(snap_strobe2), .snap_count(snap_count2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        clr;
        logic        ld;
        logic        en;
        logic        ud;
        logic [15:0] lv;
        logic        tc;    // terminal_count before the edge
        logic [15:0] cnt;   // count after the edge
        logic        wrap;  // wrap_pulse after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic clr, input logic ld, input logic en, input logic ud,
                           input logic [15:0] lv, input logic tc, input logic [15:0] cnt,
                           input logic wrap);
        vec_t v;
        v.clr = clr; v.ld = ld; v.en = en; v.ud = ud; v.lv = lv;
        v.tc = tc; v.cnt = cnt; v.wrap = wrap;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic clr, input logic ld, input logic en, input logic ud,
                         input logic [15:0] lv);
        clear = clr; load = ld; enable = en; up_down = ud; load_value = lv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a value and wait one edge.
    task automatic load_now(input logic [15:0] lv);
        drive(1'b0, 1'b1, 1'b0, 1'b1, lv);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    endtask

    logic [15:0] snap_exp;
    logic [23:0] model;
    logic        exp_tc;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        snap_strobe = 1'b0;
        clear2 = 1'b0; enable2 = 1'b0; up_down2 = 1'b1; load2 = 1'b0;
        load_value2 = 24'h0; snap_strobe2 = 1'b0;

`ifdef COUNTER_CHAIN_SNAPSHOT_EN
        snap_exp = 16'h0100;
`else
        snap_exp = 16'h0000;
`endif

        // Reset state while reset is held low across edges.
        enable = 1'b1;
        step();
        step();
        check("reset_count", 32'(count), 32'h0);
        check("reset_wrap", 32'(wrap_pulse), 32'h0);
        check("reset_snap", 32'(snap_count), 32'h0);
        check("reset_count2", 32'(count2), 32'h0);
        enable = 1'b0;
        reset = 1'b1;
        step();

        //       clr   ld    en    ud    load     tc    count    wrap
        add_vec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0001, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 16'h0999, 1'b0, 16'h0999, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h1000, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 16'h1000, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0999, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 16'h0005, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0005, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 16'h0042, 1'b0, 16'h0042, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 16'h0FAF, 1'b0, 16'h0999, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0);
        // A clear or load on a wrapping edge suppresses wrap_pulse.
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0);
        add_vec(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0);
        // Back-to-back wraps by reversing direction at each extreme.
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b1);
        add_vec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].lv);
            #1;
            check($sformatf("vec%0d tc", i), 32'(terminal_count), 32'(vecs[i].tc));
            step();
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d wrap", i), 32'(wrap_pulse), 32'(vecs[i].wrap));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Reset asserted mid-count acts without a clock edge.
        load_now(16'h0356);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step();
        check("pre_reset_count", 32'(count), 32'h0357);
        #2 reset = 1'b0;
        #1;
        check("async_reset_count", 32'(count), 32'h0);
        check("async_reset_wrap", 32'(wrap_pulse), 32'h0);
        step();
        check("held_reset_count", 32'(count), 32'h0);
        reset = 1'b1;
        step();
        check("post_reset_count", 32'(count), 32'h0001);

        // Reset clears a live wrap_pulse asynchronously.
        load_now(16'h9999);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step();
        check("wrap_before_reset", 32'(wrap_pulse), 32'h1);
        enable = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_reset_wrap2", 32'(wrap_pulse), 32'h0);
        step();
        reset = 1'b1;
        step();

        // Snapshot at the edge where 0099 becomes 0100, then held while counting on.
        load_now(16'h0099);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        snap_strobe = 1'b1;
        step();
        snap_strobe = 1'b0;
        check("snap_count_after", 32'(count), 32'h0100);
        check("snap_capture", 32'(snap_count), 32'(snap_exp));
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("snap_hold%0d", k), 32'(snap_count), 32'(snap_exp));
        end
        check("snap_run_count", 32'(count), 32'h0105);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Binary chain: directed wrap from all-ones.
        load2 = 1'b1; load_value2 = 24'hFFFFFF;
        step();
        load2 = 1'b0;
        check("bin_load", 32'(count2), 32'hFFFFFF);
        enable2 = 1'b1; up_down2 = 1'b1;
        #1;
        check("bin_tc", 32'(terminal_count2), 32'h1);
        step();
        check("bin_wrap_count", 32'(count2), 32'h0);
        check("bin_wrap_pulse", 32'(wrap_pulse2), 32'h1);
        enable2 = 1'b0;
        step();
        check("bin_wrap_fall", 32'(wrap_pulse2), 32'h0);

        // Binary chain against a 24-bit reference under random enable/direction.
        model = 24'h0;
        for (int i = 0; i < 10000; i++) begin
            enable2  = 1'($urandom_range(0, 1));
            up_down2 = 1'($urandom_range(0, 1));
            #1;
            exp_tc = enable2 && (up_down2 ? (model == 24'hFFFFFF) : (model == 24'h0));
            check("bin_rand_tc", 32'(terminal_count2), 32'(exp_tc));
            if (enable2) model = up_down2 ? model + 24'd1 : model - 24'd1;
            exp_q.push_back(model);
            step();
            check("bin_rand_count", 32'(count2), 32'(exp_q.pop_front()));
            check("bin_rand_wrap", 32'(wrap_pulse2), 32'(exp_tc));
        end
        enable2 = 1'b0;
        check("bin_snap_zero_or_held", 32'(snap_count2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
